// File: rtl/vga_timing_rx.sv
// vga_timing_rx: measures VGA line/frame geometry and a pixel checksum, flags lock on repeated geometry
module vga_timing_rx #(
  parameter int TIMEOUT = 4096,
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         Hs,
  input  logic         Vs,
  input  logic         Blank,
  input  logic [1:0]   R,
  input  logic [1:0]   G,
  input  logic [1:0]   B,
  output logic [W-1:0] h_total,
  output logic [W-1:0] h_sync,
  output logic [W-1:0] h_active,
  output logic [W-1:0] v_total,
  output logic [W-1:0] v_sync,
  output logic [W-1:0] v_active,
  output logic [W-1:0] checksum,
  output logic         frame_done,
  output logic         locked
);
  typedef enum logic [1:0] {IDLE, ACQ_FIRST, ACQ, LOCKED} state_t;
  state_t state, state_n;
  logic hs1, vs1, bl1, hs2, vs2;
  logic [5:0] rgb1;
  logic [W-1:0] hcnt, hs_cnt, act_cnt, line_len, hs_len, line_act;
  logic [W-1:0] vcnt, vs_cnt, vact_cnt, csum;
  logic [W-1:0] line_len_n, hs_len_n, line_act_n, vcnt_n, vs_cnt_n, vact_n, pix;
  logic hs_edge, vs_edge, line_had_act, timeout, upd, match;

  function automatic logic [W-1:0] sat(input logic [W-1:0] x);
    return (x == '1) ? x : x + 1'b1;
  endfunction

  assign hs_edge = hs2 & ~hs1;
  assign vs_edge = vs2 & ~vs1;
  assign line_had_act = hs_edge && act_cnt != '0;
  // an Hs edge in the same cycle restarts the line, so it never counts as a timeout
  assign timeout = hcnt >= W'(TIMEOUT) && !hs_edge;

  // values as they stand after closing any line that ends this cycle
  always_comb begin
    line_len_n = hs_edge ? hcnt : line_len;
    hs_len_n   = hs_edge ? hs_cnt : hs_len;
    line_act_n = line_had_act ? act_cnt : line_act;
    vcnt_n     = hs_edge ? sat(vcnt) : vcnt;
    vs_cnt_n   = hs_edge && !vs1 ? sat(vs_cnt) : vs_cnt;
    vact_n     = line_had_act ? sat(vact_cnt) : vact_cnt;
    pix        = bl1 ? W'(rgb1) : '0;
    upd        = vs_edge && state != IDLE && !timeout;
    match      = h_total == line_len_n && h_sync == hs_len_n && h_active == line_act_n &&
                 v_total == vcnt_n && v_sync == vs_cnt_n && v_active == vact_n;
  end

  // next state: timeout dominates, otherwise advance on each Vs edge
  always_comb begin
    state_n = state;
    if (timeout) state_n = IDLE;
    else if (vs_edge)
      state_n = state == IDLE ? ACQ_FIRST : state == ACQ_FIRST ? ACQ : match ? LOCKED : ACQ;
  end

  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  // input capture plus one cycle of sync history for edge detection
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      bl1  <= 1'b0;
      rgb1 <= '0;
      hs2  <= 1'b1;
      vs2  <= 1'b1;
    end else begin
      hs1  <= Hs;
      vs1  <= Vs;
      bl1  <= Blank;
      rgb1 <= {R, G, B};
      hs2  <= hs1;
      vs2  <= vs1;
    end

  // line and frame counters; the Vs edge cycle's pixel starts the new frame's checksum
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hcnt     <= '0;
      hs_cnt   <= '0;
      act_cnt  <= '0;
      line_len <= '0;
      hs_len   <= '0;
      line_act <= '0;
      vcnt     <= '0;
      vs_cnt   <= '0;
      vact_cnt <= '0;
      csum     <= '0;
    end else begin
      hcnt     <= hs_edge ? W'(1) : sat(hcnt);
      hs_cnt   <= hs_edge ? W'(1) : hs1 ? hs_cnt : sat(hs_cnt);
      act_cnt  <= hs_edge ? W'(bl1) : bl1 ? sat(act_cnt) : act_cnt;
      line_len <= line_len_n;
      hs_len   <= hs_len_n;
      line_act <= line_act_n;
      vcnt     <= vs_edge ? '0 : vcnt_n;
      vs_cnt   <= vs_edge ? '0 : vs_cnt_n;
      vact_cnt <= vs_edge ? '0 : vact_n;
      csum     <= (vs_edge ? '0 : csum) + pix;
    end

  // publish frame measurements and lock status
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      h_total    <= '0;
      h_sync     <= '0;
      h_active   <= '0;
      v_total    <= '0;
      v_sync     <= '0;
      v_active   <= '0;
      checksum   <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
    end else begin
      frame_done <= upd;
      locked     <= state_n == LOCKED;
      if (upd) begin
        h_total  <= line_len_n;
        h_sync   <= hs_len_n;
        h_active <= line_act_n;
        v_total  <= vcnt_n;
        v_sync   <= vs_cnt_n;
        v_active <= vact_n;
        checksum <= csum;
      end
    end
endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: drives synthetic VGA frames and checks measurements against frame-level arithmetic
module tb_vga_timing_rx;
  localparam int W = 16;
  logic clock = 1'b0, reset = 1'b1, Hs = 1'b1, Vs = 1'b1, Blank = 1'b0;
  logic [1:0] R = '0, G = '0, B = '0;
  logic [W-1:0] h_total, h_sync, h_active, v_total, v_sync, v_active, checksum;
  logic frame_done, locked;

  vga_timing_rx #(.TIMEOUT(4096), .W(W)) dut (
    .clock(clock), .reset(reset), .Hs(Hs), .Vs(Vs), .Blank(Blank), .R(R), .G(G), .B(B),
    .h_total(h_total), .h_sync(h_sync), .h_active(h_active), .v_total(v_total),
    .v_sync(v_sync), .v_active(v_active), .checksum(checksum),
    .frame_done(frame_done), .locked(locked)
  );

  always #5 clock = ~clock;

  typedef struct {int htot, hsync, hoff, hact, vtot, vsync, voff, vact, rgb, d;} geom_t;
  typedef struct {int ht, hs, ha, vt, vs, va, cs, lk;} res_t;
  typedef struct {geom_t g; res_t e;} vec_t;
  typedef geom_t gq_t[$];

  int tests = 0, fails = 0;
  int cyc = 0, vs_cyc = 0;
  logic fd_prev = 1'b0;
  res_t got[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t now_out();
    res_t r;
    r = '{int'(h_total), int'(h_sync), int'(h_active), int'(v_total),
          int'(v_sync), int'(v_active), int'(checksum), int'(locked)};
    return r;
  endfunction

  // every frame_done: record outputs, check pulse width and latency from the Vs sampling edge
  always @(negedge clock) begin
    if (frame_done) begin
      got.push_back(now_out());
      chk("fd_width", int'(fd_prev), 0);
      chk("fd_latency", cyc, vs_cyc + 1);
    end
    fd_prev = frame_done;
  end

  // one frame's expected outputs from its geometry; v_sync depends on where Vs falls in line 0
  function automatic res_t model(input geom_t g, input int dnext);
    res_t r;
    r.ht = g.htot; r.hs = g.hsync; r.ha = g.hact; r.vt = g.vtot;
    r.vs = g.vsync - 1 + (g.d > 0 ? 1 : 0) + (dnext == 0 ? 1 : 0);
    r.va = g.vact; r.cs = (g.hact * g.vact * g.rgb) % 65536; r.lk = 0;
    return r;
  endfunction

  function automatic bit same(input res_t a, input res_t b);
    return a.ht == b.ht && a.hs == b.hs && a.ha == b.ha && a.vt == b.vt && a.vs == b.vs && a.va == b.va;
  endfunction

  task automatic cmp_res(input string tag, input res_t a, input res_t e);
    chk({tag, ".h_total"}, a.ht, e.ht);
    chk({tag, ".h_sync"}, a.hs, e.hs);
    chk({tag, ".h_active"}, a.ha, e.ha);
    chk({tag, ".v_total"}, a.vt, e.vt);
    chk({tag, ".v_sync"}, a.vs, e.vs);
    chk({tag, ".v_active"}, a.va, e.va);
    chk({tag, ".checksum"}, a.cs, e.cs);
    chk({tag, ".locked"}, a.lk, e.lk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      Hs = 1'b1; Vs = 1'b1; Blank = 1'b0; {R, G, B} = 6'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; Hs = 1'b1; Vs = 1'b1; Blank = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drive_frame(input geom_t g, input int nlines);
    for (int l = 0; l < nlines; l++)
      for (int j = 0; j < g.htot; j++) begin
        int p;
        p = l * g.htot + j;
        @(negedge clock);
        Hs = j >= g.hsync;
        Vs = !(p >= g.d && p < g.d + g.vsync * g.htot);
        if (p == g.d) vs_cyc = cyc + 1;
        Blank = l >= g.voff && l < g.voff + g.vact && j >= g.hoff && j < g.hoff + g.hact;
        {R, G, B} = Blank ? 6'(g.rgb) : 6'($urandom);
      end
  endtask

  // frames starting from IDLE: the first Vs edge only acquires, the last frame only closes its predecessor
  task automatic play(input gq_t q, input int last_lines);
    int n0, n;
    res_t e[$];
    n0 = got.size();
    n = q.size();
    for (int i = 0; i < n; i++) drive_frame(q[i], (i == n - 1) ? last_lines : q[i].vtot);
    idle(3);
    for (int i = 0; i < n - 1; i++) begin
      res_t r;
      r = model(q[i], q[i + 1].d);
      r.lk = (i > 0) ? int'(same(r, e[i - 1])) : 0;
      e.push_back(r);
    end
    chk("fd_count", got.size() - n0, n - 1);
    for (int i = 0; i < n - 1 && n0 + i < got.size(); i++)
      cmp_res($sformatf("frame%0d", i), got[n0 + i], e[i]);
  endtask

  function automatic gq_t rep(input geom_t g, input int n);
    gq_t q;
    repeat (n) q.push_back(g);
    return q;
  endfunction

  function automatic geom_t rand_geom();
    geom_t g;
    g.htot = $urandom_range(16, 40);
    g.hsync = $urandom_range(1, 5);
    g.hoff = g.hsync + int'($urandom_range(0, 3));
    g.hact = $urandom_range(1, g.htot - g.hoff);
    g.vtot = $urandom_range(6, 14);
    g.vsync = $urandom_range(1, 3);
    g.voff = $urandom_range(1, 3);
    g.vact = $urandom_range(1, g.vtot - g.voff);
    g.rgb = $urandom_range(0, 63);
    g.d = $urandom_range(0, g.htot - 1);
    return g;
  endfunction

  initial begin
    vec_t tbl[3];
    geom_t s, s11, g;
    gq_t q;
    res_t zero, r;
    int n0;
    zero = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[0] = '{'{20, 4, 6, 12, 10, 2, 2, 6, 63, 0}, '{20, 4, 12, 10, 2, 6, 4536, 1}};
    tbl[1] = '{'{40, 3, 4, 32, 40, 2, 2, 36, 63, 5}, '{40, 3, 32, 40, 2, 36, 7040, 1}};
    tbl[2] = '{'{25, 5, 7, 15, 12, 3, 1, 9, 45, 11}, '{25, 5, 15, 12, 3, 9, 6075, 1}};
    s = tbl[0].g;
    s11 = s;
    s11.hact = 11;

    repeat (3) @(negedge clock);
    cmp_res("reset", now_out(), zero);
    chk("reset.frame_done", int'(frame_done), 0);
    reset = 1'b0;

    foreach (tbl[k]) begin
      do_reset();
      n0 = got.size();
      play(rep(tbl[k].g, 4), 2);
      if (got.size() >= n0 + 3) cmp_res($sformatf("vec%0d", k), got[n0 + 2], tbl[k].e);
    end

    do_reset();
    q = rep(s, 3);
    q.push_back(s11);
    q = {q, rep(s, 3)};
    play(q, 2);

    do_reset();
    play(rep(s, 4), s.vtot);
    chk("pre_timeout.locked", int'(locked), 1);
    n0 = got.size();
    idle(4200);
    r = model(s, s.d);
    cmp_res("timeout", now_out(), r);
    chk("timeout.no_fd", got.size() - n0, 0);
    play(rep(s, 3), 2);

    do_reset();
    play(rep(s, 4), 5);
    chk("pre_reset.locked", int'(locked), 1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 cmp_res("reset_mid", now_out(), zero);
    chk("reset_mid.frame_done", int'(frame_done), 0);
    @(negedge clock);
    reset = 1'b0;
    play(rep(s, 3), 2);

    for (int k = 0; k < 8; k++) begin
      q.delete();
      for (int i = 0; i < 4 + k % 3; i++) begin
        if (i > 0 && $urandom_range(0, 2) != 0) begin
          g = q[i - 1];
          g.rgb = $urandom_range(0, 63);
          if ($urandom_range(0, 3) == 0) g.d = $urandom_range(0, g.htot - 1);
        end else g = rand_geom();
        q.push_back(g);
      end
      do_reset();
      play(q, $urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
